maze_lookup_arbiter: RTL and testbench



---
 rtl/maze_pkg.sv | 21 ++
 rtl/maze_lookup_arbiter_if.sv | 26 ++
 rtl/maze_rr_arbiter.sv | 30 +++
 rtl/maze_lookup_arbiter.sv | 65 ++++++
 tb/tb_maze_lookup_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze wall-map lookup and its actors.
package maze_pkg;
  localparam int COORD_W    = 9;
  localparam int FLAG_W     = 3;
  localparam int N_REQ      = 4;
  localparam int LOOKUP_LAT = 2;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  localparam int REQ_PAC  = 0;
  localparam int REQ_MON1 = 1;
  localparam int REQ_MON2 = 2;
  localparam int REQ_MON3 = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/maze_lookup_arbiter_if.sv
// Requester/lookup bus of the shared maze lookup; slave = arbiter side.
interface maze_lookup_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 9,
  parameter int FLAG_W  = 3
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*COORD_W-1:0]  req_x;
  logic [N_REQ*COORD_W-1:0]  req_y;
  logic [COORD_W-1:0]        lk_x;
  logic [COORD_W-1:0]        lk_y;
  logic                      lk_valid;
  logic [FLAG_W-1:0]         lk_flag_L, lk_flag_U, lk_flag_R, lk_flag_D;
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ*4*FLAG_W-1:0] rsp_flags;
  logic                      busy;

  modport slave (
    input  req, req_x, req_y, lk_flag_L, lk_flag_U, lk_flag_R, lk_flag_D,
    output lk_x, lk_y, lk_valid, rsp_valid, rsp_flags, busy
  );
  modport master (
    output req, req_x, req_y, lk_flag_L, lk_flag_U, lk_flag_R, lk_flag_D,
    input  lk_x, lk_y, lk_valid, rsp_valid, rsp_flags, busy
  );
endinterface

// File: rtl/maze_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr.
module maze_rr_arbiter
  import maze_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Scan farthest-first so the closest eligible index to ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (elig[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/maze_lookup_arbiter.sv
// Shares one registered maze lookup port among N_REQ actors, round-robin,
// with a tag pipeline routing each result back as a one-cycle done pulse.
module maze_lookup_arbiter
  import maze_pkg::*;
#(
  parameter int N_REQ      = maze_pkg::N_REQ,
  parameter int LOOKUP_LAT = maze_pkg::LOOKUP_LAT,
  parameter int COORD_W    = maze_pkg::COORD_W,
  parameter int FLAG_W     = maze_pkg::FLAG_W
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_n,
  maze_lookup_arbiter_if.slave  bus
);
  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0] pending, elig, gnt, done;
  logic [IDX_W-1:0] ptr, gnt_idx;
  logic             gnt_vld;

  // Tag at stage k was issued k edges ago; stage LOOKUP_LAT meets the flags.
  logic [LOOKUP_LAT:0]            vld_pipe;
  logic [LOOKUP_LAT:0][IDX_W-1:0] idx_pipe;

  assign elig     = bus.req & ~pending;
  assign done     = vld_pipe[LOOKUP_LAT] ? (N_REQ'(1) << idx_pipe[LOOKUP_LAT]) : '0;
  assign bus.busy = |pending;

  maze_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .elig    (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      bus.lk_x      <= '0;
      bus.lk_y      <= '0;
      bus.lk_valid  <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_flags <= '0;
      pending       <= '0;
      ptr           <= '0;
      vld_pipe      <= '0;
      idx_pipe      <= '0;
    end else begin
      vld_pipe      <= {vld_pipe[LOOKUP_LAT-1:0], gnt_vld};
      idx_pipe      <= {idx_pipe[LOOKUP_LAT-1:0], gnt_idx};
      bus.lk_valid  <= gnt_vld;
      bus.rsp_valid <= done;
      pending       <= (pending & ~done) | gnt;
      if (gnt_vld) begin
        bus.lk_x <= bus.req_x[gnt_idx*COORD_W +: COORD_W];
        bus.lk_y <= bus.req_y[gnt_idx*COORD_W +: COORD_W];
        ptr      <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      for (int i = 0; i < N_REQ; i++)
        if (done[i])
          bus.rsp_flags[i*4*FLAG_W +: 4*FLAG_W] <=
            {bus.lk_flag_L, bus.lk_flag_U, bus.lk_flag_R, bus.lk_flag_D};
    end
  end
endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Randomized bench for maze_lookup_arbiter against a scheduled-response model.
module tb_maze_lookup_arbiter;
  localparam int N   = 4;
  localparam int CW  = 9;
  localparam int FW  = 3;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_lookup_arbiter_if #(.N_REQ(N), .COORD_W(CW), .FLAG_W(FW)) bus ();

  maze_lookup_arbiter #(.N_REQ(N), .LOOKUP_LAT(LAT), .COORD_W(CW), .FLAG_W(FW)) dut (
    .clk_50mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  function automatic logic [11:0] flags_of(input logic [8:0] x, input logic [8:0] y);
    logic [2:0] d;
    d = x[8:6] + y[8:6];
    return {x[2:0], y[2:0], x[5:3] ^ y[5:3], d};
  endfunction

  // Wall-map stand-in: flags for the issued coords appear LAT edges later.
  logic [8:0]  d1x, d1y, d2x, d2y;
  logic [11:0] fl;
  always @(posedge clk) begin
    d1x <= bus.lk_x; d1y <= bus.lk_y;
    d2x <= d1x;      d2y <= d1y;
  end
  assign fl = flags_of(d2x, d2y);
  assign bus.lk_flag_L = fl[11:9];
  assign bus.lk_flag_U = fl[8:6];
  assign bus.lk_flag_R = fl[5:3];
  assign bus.lk_flag_D = fl[2:0];

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: each grant schedules a response LAT+1 edges later.
  logic [8:0]  rx[N], ry[N];
  logic [N-1:0] rq;
  bit          m_pend[N];
  int          m_due[N];
  logic [11:0] m_fl[N];
  int          m_ptr, edge_n;
  logic [8:0]  e_lkx, e_lky;
  logic        e_lkv;
  logic [N-1:0] e_rspv;
  logic [N*12-1:0] e_flags;
  int          rcnt[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_due[i] = -1; m_fl[i] = '0; end
    m_ptr = 0; e_lkx = '0; e_lky = '0; e_lkv = 0; e_rspv = '0; e_flags = '0;
  endtask

  task automatic model_edge();
    int gi;
    gi = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (gi < 0 && rq[j] && !m_pend[j]) gi = j;
    end
    e_rspv = '0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_due[i] == edge_n) begin
        e_rspv[i] = 1'b1;
        e_flags[i*12 +: 12] = m_fl[i];
        m_pend[i] = 0;
      end
    e_lkv = (gi >= 0);
    if (gi >= 0) begin
      e_lkx = rx[gi]; e_lky = ry[gi];
      m_pend[gi] = 1; m_due[gi] = edge_n + LAT + 1;
      m_fl[gi] = flags_of(rx[gi], ry[gi]);
      m_ptr = (gi + 1) % N;
    end
    edge_n++;
  endtask

  task automatic drive();
    bus.req = rq;
    for (int i = 0; i < N; i++) begin
      bus.req_x[i*CW +: CW] = rx[i];
      bus.req_y[i*CW +: CW] = ry[i];
    end
  endtask

  task automatic check_all();
    logic b;
    b = 0;
    for (int i = 0; i < N; i++) b |= m_pend[i];
    chk("lk_valid",  64'(bus.lk_valid),  64'(e_lkv));
    chk("lk_x",      64'(bus.lk_x),      64'(e_lkx));
    chk("lk_y",      64'(bus.lk_y),      64'(e_lky));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rspv));
    chk("rsp_flags", 64'(bus.rsp_flags), 64'(e_flags));
    chk("busy",      64'(bus.busy),      64'(b));
    for (int i = 0; i < N; i++) rcnt[i] += int'(bus.rsp_valid[i]);
  endtask

  // One clock: inputs set before the edge, outputs checked 1 time unit after.
  task automatic cycle(input logic [N-1:0] r, input bit rand_xy);
    rq = r;
    if (rand_xy)
      for (int i = 0; i < N; i++) begin
        rx[i] = 9'($urandom_range(0, 511));
        ry[i] = 9'($urandom_range(0, 511));
      end
    drive();
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_lk_x"},      64'(bus.lk_x),      64'd0);
    chk({tag, "_lk_y"},      64'(bus.lk_y),      64'd0);
    chk({tag, "_lk_valid"},  64'(bus.lk_valid),  64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_flags"}, 64'(bus.rsp_flags), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy),      64'd0);
  endtask

  initial begin
    int mx, mn;
    edge_n = 0;
    for (int i = 0; i < N; i++) begin rx[i] = '0; ry[i] = '0; rcnt[i] = 0; end
    rq = '0;
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Single request from requester 1 at fixed coordinates.
    rx[1] = 9'd20; ry[1] = 9'd200;
    cycle(4'b0010, 0);
    chk("single_lk_x", 64'(bus.lk_x), 64'd20);
    chk("single_lk_y", 64'(bus.lk_y), 64'd200);
    repeat (5) cycle(4'b0000, 0);

    // All four requesting: order and fairness over 40 cycles.
    for (int i = 0; i < N; i++) rcnt[i] = 0;
    repeat (40) cycle(4'b1111, 1);
    repeat (4) cycle(4'b0000, 1);
    mx = rcnt[0]; mn = rcnt[0];
    for (int i = 1; i < N; i++) begin
      if (rcnt[i] > mx) mx = rcnt[i];
      if (rcnt[i] < mn) mn = rcnt[i];
    end
    chk("fair_spread_le1", 64'(mx - mn <= 1), 64'd1);
    chk("fair_nonzero",    64'(mn > 0),       64'd1);

    // Requester 2 alone, held high: re-grant every LAT+2 cycles.
    repeat (14) cycle(4'b0100, 1);
    repeat (4) cycle(4'b0000, 1);

    // Requester 3 drops right after its grant; result still returns.
    cycle(4'b1000, 1);
    repeat (6) cycle(4'b0000, 1);

    // Random traffic with coordinates changing underneath pending lookups.
    repeat (200) cycle(4'($urandom_range(0, 15)), 1);

    // Mid-flight reset after two grants.
    cycle(4'b1111, 1);
    cycle(4'b1111, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("midrst");
    @(negedge clk);
    reset_checks("midrst_hold");
    rst_n = 1'b1;
    cycle(4'b1111, 1);
    chk("post_rst_first_x", 64'(bus.lk_x), 64'(rx[0]));
    repeat (8) cycle(4'b0000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
